// File: rtl/snax_simbacore_csr_initiator.sv
// Host-side CSR initiator for SimbaCore: writes the RW CSRs (last write launches), then reads back all RO CSRs.
// Optional status polling between launch and readback is enabled by defining SNAX_SIMBACORE_CSR_POLL_EN.
module snax_simbacore_csr_initiator #(
    parameter int unsigned NumRwCsr  = 6,
    parameter int unsigned NumRoCsr  = 4,
    parameter logic [31:0] CsrBase   = 32'd0,
    parameter int unsigned StatusIdx = 0,
    parameter int unsigned PollGap   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumRwCsr-1:0][31:0] cfg_data_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    output logic [31:0]               csr_req_data_o,
    output logic [31:0]               csr_req_addr_o,
    output logic                      csr_req_write_o,
    output logic                      csr_req_valid_o,
    input  logic                      csr_req_ready_i,
    input  logic [31:0]               csr_rsp_data_i,
    input  logic                      csr_rsp_valid_i,
    output logic                      csr_rsp_ready_o,
    output logic [NumRoCsr-1:0][31:0] ro_data_o,
    output logic                      done_valid_o,
    input  logic                      done_ready_i,
    output logic [15:0]               poll_cnt_o
);

    localparam int unsigned MaxCsr = (NumRwCsr > NumRoCsr) ? NumRwCsr : NumRoCsr;
    localparam int unsigned IdxW   = $clog2(MaxCsr + 1);
    localparam int unsigned WrW    = (NumRwCsr > 1) ? $clog2(NumRwCsr) : 1;
    localparam int unsigned RoW    = (NumRoCsr > 1) ? $clog2(NumRoCsr) : 1;
    localparam logic [IdxW-1:0] LastWr = IdxW'(NumRwCsr - 1);
    localparam logic [IdxW-1:0] LastRo = IdxW'(NumRoCsr - 1);
    localparam logic [31:0]     RoBase = CsrBase + 32'(NumRwCsr);

    if (StatusIdx >= NumRoCsr || PollGap > 65535) begin : g_bad_param
        $error("snax_simbacore_csr_initiator: StatusIdx or PollGap out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
`ifdef SNAX_SIMBACORE_CSR_POLL_EN
        POLL_REQ,
        POLL_RSP,
        GAP,
`endif
        RD_REQ,
        RD_RSP,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [NumRwCsr-1:0][31:0] cfg_q;
    logic                      cfg_load;
    logic                      ro_capture;
    logic                      req_hs;
    logic                      rsp_hs;
    logic                      req_valid_d;
    logic                      req_write_d;
    logic [31:0]               req_addr_d;
    logic [31:0]               req_data_d;

    assign req_hs = csr_req_valid_o && csr_req_ready_i;
    assign rsp_hs = csr_rsp_valid_i && csr_rsp_ready_o;

`ifdef SNAX_SIMBACORE_CSR_POLL_EN
    localparam logic [31:0] StatusAddr = RoBase + 32'(StatusIdx);
    localparam int unsigned GapW = (PollGap > 0) ? $clog2(PollGap + 1) : 1;

    logic [GapW-1:0] gap_q, gap_d;
    logic            poll_inc;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cfg_load   = 1'b0;
        ro_capture = 1'b0;
`ifdef SNAX_SIMBACORE_CSR_POLL_EN
        gap_d      = gap_q;
        poll_inc   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cfg_valid_i && cfg_ready_o) begin
                    cfg_load = 1'b1;
                    idx_d    = '0;
                    state_d  = WR;
                end
            end
            WR: begin
                if (req_hs) begin
                    if (idx_q == LastWr) begin
                        idx_d = '0;
`ifdef SNAX_SIMBACORE_CSR_POLL_EN
                        state_d = POLL_REQ;
`else
                        state_d = RD_REQ;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef SNAX_SIMBACORE_CSR_POLL_EN
            POLL_REQ: begin
                if (req_hs) begin
                    poll_inc = 1'b1;
                    state_d  = POLL_RSP;
                end
            end
            POLL_RSP: begin
                if (rsp_hs) begin
                    if (csr_rsp_data_i[0]) begin
                        if (PollGap == 0) begin
                            state_d = POLL_REQ;
                        end else begin
                            gap_d   = GapW'(PollGap);
                            state_d = GAP;
                        end
                    end else begin
                        idx_d   = '0;
                        state_d = RD_REQ;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = POLL_REQ;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
`endif
            RD_REQ: begin
                if (req_hs) begin
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                if (rsp_hs) begin
                    ro_capture = 1'b1;
                    if (idx_q == LastRo) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                if (done_valid_o && done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are computed from the next state so they can be registered
    // and still appear in the first cycle of each request state.
    always_comb begin
        req_valid_d = 1'b0;
        req_write_d = 1'b0;
        req_addr_d  = '0;
        req_data_d  = '0;
        case (state_d)
            WR: begin
                req_valid_d = 1'b1;
                req_write_d = 1'b1;
                req_addr_d  = CsrBase + 32'(idx_d);
                req_data_d  = cfg_load ? cfg_data_i[0] : cfg_q[idx_d[WrW-1:0]];
            end
`ifdef SNAX_SIMBACORE_CSR_POLL_EN
            POLL_REQ: begin
                req_valid_d = 1'b1;
                req_addr_d  = StatusAddr;
            end
`endif
            RD_REQ: begin
                req_valid_d = 1'b1;
                req_addr_d  = RoBase + 32'(idx_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cfg_q           <= '0;
            ro_data_o       <= '0;
            cfg_ready_o     <= 1'b1;
            csr_req_valid_o <= 1'b0;
            csr_req_write_o <= 1'b0;
            csr_req_addr_o  <= '0;
            csr_req_data_o  <= '0;
            csr_rsp_ready_o <= 1'b0;
            done_valid_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cfg_load) begin
                cfg_q <= cfg_data_i;
            end
            if (cfg_load) begin
                ro_data_o <= '0;
            end else if (ro_capture) begin
                ro_data_o[idx_q[RoW-1:0]] <= csr_rsp_data_i;
            end
            cfg_ready_o     <= (state_d == IDLE);
            csr_req_valid_o <= req_valid_d;
            csr_req_write_o <= req_write_d;
            csr_req_addr_o  <= req_addr_d;
            csr_req_data_o  <= req_data_d;
`ifdef SNAX_SIMBACORE_CSR_POLL_EN
            csr_rsp_ready_o <= (state_d == RD_RSP) || (state_d == POLL_RSP);
`else
            csr_rsp_ready_o <= (state_d == RD_RSP);
`endif
            done_valid_o    <= (state_d == DONE);
        end
    end

`ifdef SNAX_SIMBACORE_CSR_POLL_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap_q      <= '0;
            poll_cnt_o <= '0;
        end else begin
            gap_q <= gap_d;
            if (cfg_load) begin
                poll_cnt_o <= '0;
            end else if (poll_inc && (poll_cnt_o != 16'hFFFF)) begin
                poll_cnt_o <= poll_cnt_o + 16'd1;
            end
        end
    end
`else
    assign poll_cnt_o = '0;
`endif

endmodule
